// File: rtl/commit_trace_sequencer_pkg.sv
// Shared definitions for the commit trace sequencer.
//   - Field widths of one trace record (scalar data, PC, logical register, rtype).
//   - trace_entry_t: one buffered retirement as presented to the trace consumer.
//   - popcount(): number of set bits in a lane mask (up to MAX_LANES lanes).
// Ports: none (package).
package commit_trace_pkg;

  localparam int XLEN      = 64;
  localparam int ADDR_BITS = 40;
  localparam int LREG_SZ   = 5;
  localparam int SEQ_W     = 64;
  localparam int INST_W    = 32;
  localparam int RTYPE_W   = 3;
  localparam int MAX_LANES = 32;
  localparam int POPCNT_W  = 6;

  typedef struct packed {
    logic [SEQ_W-1:0]     seq;
    logic [ADDR_BITS-1:0] pc;
    logic [INST_W-1:0]    inst;
    logic [LREG_SZ-1:0]   ldst;
    logic [RTYPE_W-1:0]   rtype;
    logic [XLEN-1:0]      wdata;
  } trace_entry_t;

  function automatic logic [POPCNT_W-1:0] popcount(input logic [MAX_LANES-1:0] bits);
    logic [POPCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      cnt = cnt + POPCNT_W'(bits[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/commit_trace_sequencer_if.sv
// Single-beat trace stream between the sequencer and its consumer.
//   trace_valid  head entry available (master -> slave)
//   trace_ready  consumer accepts the head entry (slave -> master)
//   trace_seq/pc/inst/ldst/rtype/wdata  head entry fields (master -> slave)
// Modports: master = sequencer side, slave = consumer side.
interface commit_trace_sequencer_if;
  import commit_trace_pkg::*;

  logic                 trace_valid;
  logic                 trace_ready;
  logic [SEQ_W-1:0]     trace_seq;
  logic [ADDR_BITS-1:0] trace_pc;
  logic [INST_W-1:0]    trace_inst;
  logic [LREG_SZ-1:0]   trace_ldst;
  logic [RTYPE_W-1:0]   trace_rtype;
  logic [XLEN-1:0]      trace_wdata;

  modport master (
    output trace_valid, trace_seq, trace_pc, trace_inst, trace_ldst, trace_rtype, trace_wdata,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_seq, trace_pc, trace_inst, trace_ldst, trace_rtype, trace_wdata,
    output trace_ready
  );

endinterface

// File: rtl/commit_lane_compactor.sv
// Combinational lane compactor for one commit group.
//   v          in   per-lane valid mask, lane 0 oldest
//   src_lane   out  for output slot k, the lane index that lands in it
//   slot_used  out  slot k carries a retirement
//   n          out  number of valid lanes in the group
// Holes in v are squeezed out: the k-th set bit of v (from lane 0 up) maps to slot k.
module commit_lane_compactor
  import commit_trace_pkg::*;
#(
  parameter int RETIRE_WIDTH = 6,
  localparam int IDX_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1,
  localparam int CNT_W = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic [RETIRE_WIDTH-1:0]            v,
  output logic [RETIRE_WIDTH-1:0][IDX_W-1:0] src_lane,
  output logic [RETIRE_WIDTH-1:0]            slot_used,
  output logic [CNT_W-1:0]                   n
);

  logic [RETIRE_WIDTH-1:0][CNT_W-1:0] offset;
  logic [MAX_LANES-1:0]               v_ext;

  // Exclusive prefix sum: offset[i] = number of valid lanes older than lane i.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_W'(v[i]);
    end
  end

  // Invert the prefix sum into a slot -> lane selection.
  always_comb begin
    src_lane  = '0;
    slot_used = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (v[i] && (offset[i] == CNT_W'(k))) begin
          src_lane[k]  = IDX_W'(i);
          slot_used[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    v_ext                   = '0;
    v_ext[RETIRE_WIDTH-1:0] = v;
  end

  assign n = CNT_W'(popcount(v_ext));

endmodule

// File: rtl/commit_trace_sequencer.sv
// Serializes the multi-lane commit stream into one ordered trace beat per retirement.
//   clock, reset            sole clock, synchronous active-high reset
//   enable                  when low, commit groups are ignored entirely
//   commit_*                per-lane commit debug buses, lane i at [i*W +: W]
//   trace (master)          first-word fall-through trace stream with valid/ready
//   occupancy               entries currently buffered
//   overflow, drop_count    sticky loss flag and saturating dropped-retirement count
//   clear_overflow          clears overflow/drop_count (a same-cycle drop wins)
// The core is never stalled: a group that does not fit is dropped whole, and its
// sequence numbers are still consumed so the consumer sees a gap.
module commit_trace_sequencer
  import commit_trace_pkg::*;
#(
  parameter int RETIRE_WIDTH = 6,
  parameter int DEPTH        = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [RETIRE_WIDTH-1:0]           commit_arch_valids,
  input  logic [RETIRE_WIDTH*ADDR_BITS-1:0] commit_pc,
  input  logic [RETIRE_WIDTH*INST_W-1:0]    commit_inst,
  input  logic [RETIRE_WIDTH*LREG_SZ-1:0]   commit_ldst,
  input  logic [RETIRE_WIDTH*RTYPE_W-1:0]   commit_dst_rtype,
  input  logic [RETIRE_WIDTH*XLEN-1:0]      commit_wdata,
  commit_trace_sequencer_if.master          trace,
  output logic [$clog2(DEPTH):0]            occupancy,
  output logic                              overflow,
  output logic [31:0]                       drop_count,
  input  logic                              clear_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int IDX_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;
  localparam int CNT_W = $clog2(RETIRE_WIDTH + 1);

  function automatic logic [31:0] sat_drop(input logic [31:0] cur, input logic [CNT_W-1:0] add);
    logic [32:0] sum;
    sum = {1'b0, cur} + 33'(add);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic [RETIRE_WIDTH-1:0]            v;
  logic [RETIRE_WIDTH-1:0][IDX_W-1:0] src_lane;
  logic [RETIRE_WIDTH-1:0]            slot_used;
  logic [CNT_W-1:0]                   n_grp;
  logic [OCC_W-1:0]                   free_slots;
  logic [OCC_W-1:0]                   n_acc;
  logic                               accept;
  logic                               drop;
  logic                               pop;

  logic [PTR_W-1:0]                   wr_ptr;
  logic [PTR_W-1:0]                   rd_ptr;
  logic [SEQ_W-1:0]                   seq_ctr;
  trace_entry_t                       mem [DEPTH];
  trace_entry_t                       wr_entry [RETIRE_WIDTH];

  assign v = commit_arch_valids & {RETIRE_WIDTH{enable}};

  commit_lane_compactor #(.RETIRE_WIDTH(RETIRE_WIDTH)) u_compactor (
    .v         (v),
    .src_lane  (src_lane),
    .slot_used (slot_used),
    .n         (n_grp)
  );

  // Space check uses registered occupancy only; a same-cycle pop frees nothing yet.
  assign free_slots = OCC_W'(DEPTH) - occupancy;
  assign accept     = (OCC_W'(n_grp) <= free_slots);
  assign drop       = (n_grp != '0) && !accept;
  assign n_acc      = accept ? OCC_W'(n_grp) : '0;
  assign pop        = trace.trace_valid && trace.trace_ready;

  // Gather the compacted lanes into records stamped with consecutive sequence numbers.
  always_comb begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      wr_entry[k].seq   = seq_ctr + SEQ_W'(k);
      wr_entry[k].pc    = commit_pc[int'(src_lane[k])*ADDR_BITS +: ADDR_BITS];
      wr_entry[k].inst  = commit_inst[int'(src_lane[k])*INST_W +: INST_W];
      wr_entry[k].ldst  = commit_ldst[int'(src_lane[k])*LREG_SZ +: LREG_SZ];
      wr_entry[k].rtype = commit_dst_rtype[int'(src_lane[k])*RTYPE_W +: RTYPE_W];
      wr_entry[k].wdata = commit_wdata[int'(src_lane[k])*XLEN +: XLEN];
    end
  end

  // Storage write: only free slots are touched, so the head stays stable under backpressure.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (slot_used[k]) begin
          mem[wr_ptr + PTR_W'(k)] <= wr_entry[k];
        end
      end
    end
  end

  // Pointer, occupancy, sequence and loss bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      seq_ctr    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(n_acc);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      occupancy <= occupancy + n_acc - OCC_W'(pop);
      seq_ctr   <= seq_ctr + SEQ_W'(n_grp);
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= clear_overflow ? 32'(n_grp) : sat_drop(drop_count, n_grp);
      end else if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  assign trace.trace_valid = (occupancy != '0);
  assign trace.trace_seq   = mem[rd_ptr].seq;
  assign trace.trace_pc    = mem[rd_ptr].pc;
  assign trace.trace_inst  = mem[rd_ptr].inst;
  assign trace.trace_ldst  = mem[rd_ptr].ldst;
  assign trace.trace_rtype = mem[rd_ptr].rtype;
  assign trace.trace_wdata = mem[rd_ptr].wdata;

endmodule

// File: tb/tb_commit_trace_sequencer.sv
// Directed scoreboard bench for commit_trace_sequencer (RETIRE_WIDTH = 6, DEPTH = 16).
module tb_commit_trace_sequencer;
  import commit_trace_pkg::*;

  localparam int RW    = 6;
  localparam int DEPTH = 16;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    clear_overflow;
  logic [RW-1:0]           commit_arch_valids;
  logic [RW*ADDR_BITS-1:0] commit_pc;
  logic [RW*INST_W-1:0]    commit_inst;
  logic [RW*LREG_SZ-1:0]   commit_ldst;
  logic [RW*RTYPE_W-1:0]   commit_dst_rtype;
  logic [RW*XLEN-1:0]      commit_wdata;
  logic [$clog2(DEPTH):0]  occupancy;
  logic                    overflow;
  logic [31:0]             drop_count;

  commit_trace_sequencer_if tif ();

  commit_trace_sequencer #(.RETIRE_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable),
    .commit_arch_valids (commit_arch_valids),
    .commit_pc          (commit_pc),
    .commit_inst        (commit_inst),
    .commit_ldst        (commit_ldst),
    .commit_dst_rtype   (commit_dst_rtype),
    .commit_wdata       (commit_wdata),
    .trace              (tif),
    .occupancy          (occupancy),
    .overflow           (overflow),
    .drop_count         (drop_count),
    .clear_overflow     (clear_overflow)
  );

  always #5 clock = ~clock;

  logic [ADDR_BITS-1:0] lane_pc    [RW];
  logic [INST_W-1:0]    lane_inst  [RW];
  logic [LREG_SZ-1:0]   lane_ldst  [RW];
  logic [RTYPE_W-1:0]   lane_rtype [RW];
  logic [XLEN-1:0]      lane_wdata [RW];

  trace_entry_t q[$];
  logic [63:0]  seq_m;
  logic         m_ovf;
  logic [31:0]  m_drop;
  int           vectors;
  int           miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_model(input logic [31:0] a, input int n);
    logic [63:0] s;
    s = 64'(a) + 64'(n);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic set_lanes(input logic [ADDR_BITS-1:0] base);
    for (int i = 0; i < RW; i++) begin
      lane_pc[i]    = base + ADDR_BITS'(4 * i);
      lane_inst[i]  = {base[23:8], 8'(i), 8'h13};
      lane_ldst[i]  = LREG_SZ'(base[4:0]) + LREG_SZ'(i + 1);
      lane_rtype[i] = RTYPE_W'(i + 1);
      lane_wdata[i] = {base[31:0], 32'hC0DE_0000 | 32'(i)};
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < RW; i++) begin
      commit_pc[i*ADDR_BITS +: ADDR_BITS]      = lane_pc[i];
      commit_inst[i*INST_W +: INST_W]          = lane_inst[i];
      commit_ldst[i*LREG_SZ +: LREG_SZ]        = lane_ldst[i];
      commit_dst_rtype[i*RTYPE_W +: RTYPE_W]   = lane_rtype[i];
      commit_wdata[i*XLEN +: XLEN]             = lane_wdata[i];
    end
  endtask

  // Called at a falling edge: checks current outputs, drives one cycle of stimulus,
  // updates the scoreboard for the coming rising edge, and returns at the next falling edge.
  task automatic cycle(input logic [RW-1:0] v, input logic rdy, input logic en, input logic clr);
    int           free_m;
    int           n;
    int           k;
    trace_entry_t e;
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("trace_valid", 64'(tif.trace_valid), 64'(q.size() != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    if (q.size() != 0) begin
      check("head_seq", tif.trace_seq, q[0].seq);
      check("head_pc", 64'(tif.trace_pc), 64'(q[0].pc));
      check("head_inst", 64'(tif.trace_inst), 64'(q[0].inst));
      check("head_ldst", 64'(tif.trace_ldst), 64'(q[0].ldst));
      check("head_rtype", 64'(tif.trace_rtype), 64'(q[0].rtype));
      check("head_wdata", tif.trace_wdata, q[0].wdata);
    end
    commit_arch_valids = v;
    tif.trace_ready    = rdy;
    enable             = en;
    clear_overflow     = clr;
    drive_lanes();
    free_m = DEPTH - q.size();
    n = 0;
    for (int i = 0; i < RW; i++) if (v[i] && en) n++;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (n != 0 && n <= free_m) begin
      k = 0;
      for (int i = 0; i < RW; i++) begin
        if (v[i] && en) begin
          e.seq   = seq_m + 64'(k);
          e.pc    = lane_pc[i];
          e.inst  = lane_inst[i];
          e.ldst  = lane_ldst[i];
          e.rtype = lane_rtype[i];
          e.wdata = lane_wdata[i];
          q.push_back(e);
          k++;
        end
      end
    end
    if (n != 0 && n > free_m) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 32'(n) : sat_model(m_drop, n);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end
    seq_m = seq_m + 64'(n);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input logic [RW-1:0] v);
    reset              = 1'b1;
    commit_arch_valids = v;
    enable             = 1'b1;
    clear_overflow     = 1'b0;
    tif.trace_ready    = 1'b0;
    drive_lanes();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    seq_m  = '0;
    m_ovf  = 1'b0;
    m_drop = '0;
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    commit_arch_valids = '0;
    commit_pc          = '0;
    commit_inst        = '0;
    commit_ldst        = '0;
    commit_dst_rtype   = '0;
    commit_wdata       = '0;
    enable             = 1'b1;
    clear_overflow     = 1'b0;
    tif.trace_ready    = 1'b0;
    set_lanes(40'h0);

    // Reset state
    do_reset('0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_valid", 64'(tif.trace_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);

    // Single lane, one-cycle latency
    set_lanes(40'h1000);
    cycle(6'b000001, 1'b1, 1'b1, 1'b0);
    check("single_valid", 64'(tif.trace_valid), 64'd1);
    check("single_seq", tif.trace_seq, 64'd0);
    check("single_pc", 64'(tif.trace_pc), 64'h1000);
    cycle('0, 1'b1, 1'b1, 1'b0);
    check("single_after_valid", 64'(tif.trace_valid), 64'd0);
    cycle('0, 1'b1, 1'b1, 1'b0);

    // Full group drains in lane order
    do_reset('0);
    set_lanes(40'h0);
    cycle(6'b111111, 1'b1, 1'b1, 1'b0);
    check("full_occupancy", 64'(occupancy), 64'd6);
    check("full_first_pc", 64'(tif.trace_pc), 64'h0);
    repeat (7) cycle('0, 1'b1, 1'b1, 1'b0);

    // Sparse group is compacted
    do_reset('0);
    set_lanes(40'hA000);
    cycle(6'b101001, 1'b1, 1'b1, 1'b0);
    check("sparse_pc0", 64'(tif.trace_pc), 64'hA000);
    check("sparse_seq0", tif.trace_seq, 64'd0);
    cycle('0, 1'b1, 1'b1, 1'b0);
    check("sparse_pc1", 64'(tif.trace_pc), 64'hA00C);
    check("sparse_seq1", tif.trace_seq, 64'd1);
    cycle('0, 1'b1, 1'b1, 1'b0);
    check("sparse_pc2", 64'(tif.trace_pc), 64'hA014);
    check("sparse_seq2", tif.trace_seq, 64'd2);
    set_lanes(40'hB000);
    cycle(6'b000001, 1'b1, 1'b1, 1'b0);
    check("sparse_next_seq", tif.trace_seq, 64'd3);
    repeat (2) cycle('0, 1'b1, 1'b1, 1'b0);

    // Overflow drops the third full group; disabled commits consume no sequence numbers
    do_reset('0);
    set_lanes(40'h2000);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    set_lanes(40'h3000);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    set_lanes(40'h4000);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    check("ovf_occupancy", 64'(occupancy), 64'd12);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop_count", 64'(drop_count), 64'd6);
    repeat (12) cycle('0, 1'b1, 1'b1, 1'b0);
    cycle(6'b111111, 1'b1, 1'b0, 1'b0);
    set_lanes(40'h5000);
    cycle(6'b000001, 1'b1, 1'b1, 1'b0);
    check("ovf_resume_seq", tif.trace_seq, 64'd18);
    repeat (2) cycle('0, 1'b1, 1'b1, 1'b0);

    // Full FIFO with toggling ready and single-lane pushes across pointer wrap
    do_reset('0);
    set_lanes(40'h6000);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    set_lanes(40'h7000);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    set_lanes(40'h8000);
    cycle(6'b001111, 1'b0, 1'b1, 1'b0);
    check("bp_full_occupancy", 64'(occupancy), 64'd16);
    for (int c = 0; c < 40; c++) begin
      set_lanes(40'h9000 + ADDR_BITS'(c * 64));
      cycle(6'b000001, 1'(c % 2), 1'b1, 1'b0);
    end
    repeat (18) cycle('0, 1'b1, 1'b1, 1'b0);

    // Reset mid-operation flushes buffered entries and commits in the reset cycle
    do_reset('0);
    set_lanes(40'hA0000);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    cycle(6'b001111, 1'b0, 1'b1, 1'b0);
    check("mid_occupancy", 64'(occupancy), 64'd10);
    do_reset(6'b111111);
    check("mid_rst_occupancy", 64'(occupancy), 64'd0);
    check("mid_rst_valid", 64'(tif.trace_valid), 64'd0);
    set_lanes(40'hB0000);
    cycle(6'b000001, 1'b1, 1'b1, 1'b0);
    check("mid_first_seq", tif.trace_seq, 64'd0);
    check("mid_first_pc", 64'(tif.trace_pc), 64'hB0000);
    cycle('0, 1'b1, 1'b1, 1'b0);

    // Clear coinciding with a drop keeps the flag and restarts the count at n
    do_reset('0);
    set_lanes(40'hC000);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    cycle(6'b111111, 1'b0, 1'b1, 1'b0);
    cycle(6'b000001, 1'b0, 1'b1, 1'b0);
    cycle(6'b001111, 1'b0, 1'b1, 1'b1);
    check("clr_drop_overflow", 64'(overflow), 64'd1);
    check("clr_drop_count", 64'(drop_count), 64'd4);
    cycle('0, 1'b0, 1'b1, 1'b1);
    check("clr_only_overflow", 64'(overflow), 64'd0);
    check("clr_only_count", 64'(drop_count), 64'd0);
    repeat (15) cycle('0, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/commit_trace_sequencer.md
Name: commit_trace_sequencer

Overview:
- Serializes the per-cycle multi-lane commit stream of the core (up to RETIRE_WIDTH retirements per cycle) into a single ordered trace stream, one retirement per beat, with valid/ready backpressure.
- Sits between the core commit debug signals and a single-port trace consumer (co-sim checker, logger).
- The core can never be stalled by tracing. On insufficient buffer space the block drops whole commit groups and reports the loss with a sticky flag and a counter.
- Every retirement carries a global sequence number so the consumer can detect gaps.

Parameters:
- RETIRE_WIDTH, 6, number of commit lanes; must be ≤ DEPTH.
- DEPTH, 16, trace FIFO entries; power of two.
- XLEN, 64, scalar writeback data width.
- ADDR_BITS, 40, PC width.
- LREG_SZ, 5, logical register index width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, incoming commits are ignored (not counted, not sequenced).
- commit_arch_valids  in  RETIRE_WIDTH  per-lane retire valid; lane 0 is oldest.
- commit_pc  in  RETIRE_WIDTH*ADDR_BITS  lane i at [i*ADDR_BITS +: ADDR_BITS].
- commit_inst  in  RETIRE_WIDTH*32  instruction bits per lane.
- commit_ldst  in  RETIRE_WIDTH*LREG_SZ  destination logical register per lane.
- commit_dst_rtype  in  RETIRE_WIDTH*3  destination register type per lane.
- commit_wdata  in  RETIRE_WIDTH*XLEN  writeback data per lane.
- trace_valid  out  1  head entry available.
- trace_ready  in  1  consumer accepts head entry.
- trace_seq  out  64  retirement index of head entry.
- trace_pc  out  ADDR_BITS  head entry field.
- trace_inst  out  32  head entry field.
- trace_ldst  out  LREG_SZ  head entry field.
- trace_rtype  out  3  head entry field.
- trace_wdata  out  XLEN  head entry field.
- occupancy  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky drop indicator.
- drop_count  out  32  retirements dropped since last clear; saturating.
- clear_overflow  in  1  clears overflow and drop_count.

Behaviour:
- Reset (synchronous, active-high):
  - Read/write pointers, occupancy and seq counter go to 0; overflow = 0; drop_count = 0; trace_valid = 0.
  - Reset asserted mid-operation flushes all buffered entries. Commits presented in the reset cycle are discarded.
- Group accept:
  - v = commit_arch_valids & {RETIRE_WIDTH{enable}}; n = popcount(v).
  - free = DEPTH − occupancy, using registered occupancy only. A same-cycle pop gives no credit.
  - If n ≤ free, all n valid lanes are written in ascending lane order to consecutive slots starting at wr_ptr. Holes are compacted: v = 6'b101001 writes lanes 0, 3, 5 in that order.
  - If n > free, the entire group is dropped (never partially accepted). overflow <= 1; drop_count <= sat(drop_count + n).
- Sequencing:
  - The lane written k-th in a group (k from 0) gets seq = seq_ctr + k.
  - seq_ctr <= seq_ctr + n for every enabled group, accepted or dropped, so dropped groups appear as seq gaps.
  - seq_ctr wraps at 2^64.
- Output:
  - First-word fall-through: head fields are driven from storage at rd_ptr; trace_valid = (occupancy != 0).
  - Latency: a commit in cycle t is visible on trace_* in cycle t+1 when the FIFO was empty.
  - Pop occurs when trace_valid && trace_ready. Head fields must hold stable while trace_valid && !trace_ready.
- Pointers and occupancy:
  - Pointers wrap modulo DEPTH.
  - occupancy <= occupancy + n_accepted − pop. Simultaneous push and pop are allowed in every state, including full (pop frees space only for the next cycle).
- Clear/overflow collisions:
  - clear_overflow with no drop in the same cycle: overflow <= 0, drop_count <= 0.
  - clear_overflow with a drop in the same cycle: overflow <= 1, drop_count <= n.
- drop_count saturates at 32'hFFFF_FFFF.
- n = 0 cycles change nothing except the pop path.

Decomposition:
- Package commit_trace_pkg:
  - trace_entry_t struct holding seq, pc, inst, ldst, rtype, wdata.
  - Width localparams and a popcount function.
- Sub-module commit_lane_compactor (combinational):
  - Prefix-sum of v gives each valid lane its slot offset, output index and n.
  - Instantiated once and kept separately testable.
- The top level holds storage, pointers, counters and overflow logic.

Test Plan:
- Single lane: v = 6'b000001, pc = 0x1000, trace_ready = 1 → next cycle trace_valid = 1, seq = 0, pc = 0x1000; following cycle trace_valid = 0.
- Full group: v = 6'b111111 with pcs 0x0/0x4/…/0x14, ready = 1 → six beats, seq 0..5, pcs in lane order, occupancy 6→0.
- Sparse group: v = 6'b101001 with lane pcs A/B/C → beats pc A, B, C with seq 0, 1, 2; next group seq starts at 3.
- Overflow: ready = 0, three full groups (DEPTH = 16) → first two accepted (occupancy 12), third dropped: overflow = 1, drop_count = 6; next accepted entry after drain has seq 18.
- Backpressure with wrap: hold occupancy at 16 with ready toggling every cycle, push 1-lane groups for 40 cycles → no drop except when free = 0; seq strictly increasing with gaps only at drops; head stable while ready = 0.
- Reset and clear: assert reset with 10 entries buffered → next cycle occupancy = 0, trace_valid = 0, first new entry seq = 0. Then clear_overflow coincident with a drop of n = 4 → overflow = 1, drop_count = 4.
